// File: rtl/m68k_wb_bridge.sv
// m68k_wb_bridge: 68000-style asynchronous bus slave to Wishbone classic master.
// A 16-bit CPU access becomes one 32-bit Wishbone cycle. The CPU is answered with
// DTACK on ack or BERR on err/timeout. The reply is held until the CPU releases AS.
//
//   state | meaning
//   IDLE  | waiting for a qualified AS/UDS/LDS assertion
//   BUS   | Wishbone cycle in flight, cycle counter running
//   DTACK | cpu_ndtack_o asserted, waiting for AS to go high
//   BERR  | cpu_nberr_o asserted, waiting for AS to go high
module m68k_wb_bridge #(
  parameter int AWIDTH  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [AWIDTH-1:1] cpu_addr_i,
  input  logic [15:0]       cpu_dat_i,
  output logic [15:0]       cpu_dat_o,
  output logic              cpu_dat_oe_o,
  input  logic              cpu_nas_i,
  input  logic              cpu_nuds_i,
  input  logic              cpu_nlds_i,
  input  logic              cpu_rnw_i,
  output logic              cpu_ndtack_o,
  output logic              cpu_nberr_o,
  output logic [AWIDTH-1:0] wb_addr_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  output logic [3:0]        wb_sel_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, DTACK, BERR} state_t;

  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t     state_q, state_d;
  logic [1:0] as_ff, uds_ff, lds_ff;
  logic [1:0] fill_q;
  logic       as_s, uds_s, lds_s;
  logic       armed_q;
  logic       abort_q;
  logic       a1_q;
  logic [7:0] cnt_q;
  logic       start, bus_ack, bus_err;
  logic       timeout_hit, aborting;

  assign as_s  = as_ff[1];
  assign uds_s = uds_ff[1];
  assign lds_s = lds_ff[1];

  // A cycle has timed out when this clock's increment would reach TIMEOUT.
  assign timeout_hit = ({1'b0, cnt_q} + 9'd1) == TIMEOUT_W;
  assign aborting    = abort_q | as_s;
  assign wb_stb_o    = wb_cyc_o;

  // Two-flop synchronizers for the CPU strobes. fill_q marks when the chain holds real samples.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      as_ff  <= 2'b11;
      uds_ff <= 2'b11;
      lds_ff <= 2'b11;
      fill_q <= 2'b00;
    end else begin
      as_ff  <= {as_ff[0], cpu_nas_i};
      uds_ff <= {uds_ff[0], cpu_nuds_i};
      lds_ff <= {lds_ff[0], cpu_nlds_i};
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  // Arm only after a genuine AS-high sample, so AS held low through reset cannot start a cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      armed_q <= 1'b0;
    end else if (start) begin
      armed_q <= 1'b0;
    end else if (fill_q[1] && as_s) begin
      armed_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic. err beats ack, and ack beats timeout.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    bus_ack = 1'b0;
    bus_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && !as_s && (!uds_s || !lds_s)) begin
          start   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (wb_err_i || (!wb_ack_i && timeout_hit)) begin
          bus_err = 1'b1;
          state_d = aborting ? IDLE : BERR;
        end else if (wb_ack_i) begin
          bus_ack = 1'b1;
          state_d = aborting ? IDLE : DTACK;
        end
      end
      DTACK, BERR: begin
        if (as_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus-cycle counter (saturating) and sticky CPU-abort flag. Both clear on entry to BUS.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cnt_q   <= 8'd0;
      abort_q <= 1'b0;
    end else if (start) begin
      cnt_q   <= 8'd0;
      abort_q <= 1'b0;
    end else if (state_q == BUS) begin
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      if (as_s)           abort_q <= 1'b1;
    end
  end

  // Registered Wishbone request and CPU-side handshake outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_addr_o    <= '0;
      wb_dat_o     <= 32'd0;
      wb_sel_o     <= 4'd0;
      wb_we_o      <= 1'b0;
      wb_cyc_o     <= 1'b0;
      a1_q         <= 1'b0;
      cpu_dat_o    <= 16'd0;
      cpu_dat_oe_o <= 1'b0;
      cpu_ndtack_o <= 1'b1;
      cpu_nberr_o  <= 1'b1;
    end else begin
      if (start) begin
        wb_addr_o <= {cpu_addr_i[AWIDTH-1:2], 2'b00};
        wb_we_o   <= ~cpu_rnw_i;
        wb_dat_o  <= {cpu_dat_i, cpu_dat_i};
        wb_sel_o  <= cpu_addr_i[1] ? {2'b00, ~uds_s, ~lds_s} : {~uds_s, ~lds_s, 2'b00};
        wb_cyc_o  <= 1'b1;
        a1_q      <= cpu_addr_i[1];
      end
      if (bus_ack) cpu_dat_o <= a1_q ? wb_dat_i[15:0] : wb_dat_i[31:16];
      if (bus_ack || bus_err) begin
        wb_cyc_o <= 1'b0;
        wb_we_o  <= 1'b0;
      end
      if (bus_ack && state_d == DTACK) begin
        cpu_ndtack_o <= 1'b0;
        cpu_dat_oe_o <= ~wb_we_o;
      end
      if (bus_err && state_d == BERR) cpu_nberr_o <= 1'b0;
      if ((state_q == DTACK || state_q == BERR) && state_d == IDLE) begin
        cpu_ndtack_o <= 1'b1;
        cpu_nberr_o  <= 1'b1;
        cpu_dat_oe_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/m68k_wb_bridge.md
M68K_WB_BRIDGE -- requirements
Module: m68k_wb_bridge

Interface
REQ-001 SHALL have parameters: AWIDTH, 24, byte-address width on both the CPU and bus sides; TIMEOUT, 255, maximum bus cycles to wait for ack before bus error (1..255).
REQ-002 SHALL have ports: wb_clk_i in 1, single clock; wb_rst_n_i in 1, reset.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have CPU-side ports: cpu_addr_i in AWIDTH-1 (A[AWIDTH-1:1]); cpu_dat_i in 16; cpu_dat_o out 16; cpu_dat_oe_o out 1, data-bus drive enable; cpu_nas_i, cpu_nuds_i, cpu_nlds_i, cpu_rnw_i in 1 each (asynchronous to wb_clk_i); cpu_ndtack_o out 1; cpu_nberr_o out 1.
REQ-005 SHALL have Wishbone master ports: wb_addr_o out AWIDTH; wb_dat_o out 32; wb_dat_i in 32; wb_sel_o out 4; wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_ack_i, wb_err_i in 1.

Function
REQ-006 SHALL pass cpu_nas_i, cpu_nuds_i and cpu_nlds_i through 2-flop synchronizers before any use; cpu_addr_i, cpu_dat_i and cpu_rnw_i are sampled only when the synchronized strobes qualify.
REQ-007 SHALL implement FSM states IDLE, BUS, DTACK and BERR.
REQ-008 IDLE->BUS SHALL occur when synchronized AS is low and UDS or LDS is low.
REQ-009 On the IDLE->BUS edge, the block SHALL register all of the following:
- wb_addr_o = {A[AWIDTH-1:2],2'b00}.
- wb_we_o = ~cpu_rnw_i.
- wb_dat_o = {cpu_dat_i,cpu_dat_i}.
- wb_sel_o = A1 ? {2'b00,~uds,~lds} : {~uds,~lds,2'b00} (big-endian; A1=0 selects bits 31:16).
- wb_cyc_o = wb_stb_o = 1.
REQ-010 Latency: wb_stb_o SHALL rise on the 3rd rising edge after the strobes fall, given input setup is met.
REQ-011 In BUS, the block SHALL hold cyc/stb/addr/sel/we/dat stable and increment a cycle counter each clock.
REQ-012 BUS->DTACK SHALL occur on wb_ack_i, with these effects on the same edge:
- cyc/stb/we drop.
- cpu_dat_o latches A1 ? wb_dat_i[15:0] : wb_dat_i[31:16].
- cpu_ndtack_o goes low.
- cpu_dat_oe_o goes high if the cycle is a read.
REQ-013 BUS->BERR SHALL occur on wb_err_i, or when the counter reaches TIMEOUT without ack; cyc/stb drop and cpu_nberr_o goes low.
REQ-014 Simultaneous events in BUS SHALL resolve as follows: wb_err_i beats wb_ack_i; wb_ack_i beats timeout in the same cycle.
REQ-015 DTACK and BERR SHALL hold their strobe low until synchronized AS is high, then go to IDLE with cpu_ndtack_o=1, cpu_nberr_o=1 and cpu_dat_oe_o=0 registered on that edge.
REQ-016 If synchronized AS goes high while in BUS (CPU abort), the block SHALL continue to ack/err/timeout and then go straight to IDLE without asserting cpu_ndtack_o or cpu_nberr_o.
REQ-017 The cycle counter SHALL clear on entry to BUS, SHALL never wrap, and SHALL be 8 bits.
REQ-018 A new cycle SHALL NOT start until the FSM has returned to IDLE, so back-to-back CPU cycles need AS high for at least 1 synchronized sample.
REQ-019 wb_stb_o SHALL equal wb_cyc_o at all times.

Reset
REQ-020 While wb_rst_n_i is low, the block SHALL asynchronously force:
- FSM to IDLE; counter to 0.
- Synchronizer flops to 1.
- wb_cyc_o, wb_stb_o, wb_we_o = 0.
- wb_sel_o = 0; wb_addr_o = 0; wb_dat_o = 0; cpu_dat_o = 0.
- cpu_dat_oe_o = 0; cpu_ndtack_o = 1; cpu_nberr_o = 1.
REQ-021 Reset asserted mid-cycle SHALL drop the Wishbone cycle immediately with no ack pending.
REQ-022 After reset release, the block SHALL start a cycle only once it has seen a fresh AS-low through the synchronizers.

Verification
REQ-023 Word write: A=0x001000, A1=0, UDS=LDS=0, D=0xBEEF, ack after 2 cycles -> expect:
- wb_addr_o=0x001000, sel=1100, we=1, wb_dat_o=0xBEEFBEEF.
- ndtack low until AS high.
REQ-024 Byte read: A=0x001002, LDS only, wb_dat_i=0x11223344 -> expect:
- sel=0001.
- cpu_dat_o=0x3344, oe=1 while DTACK.
- oe=0 after AS high.
REQ-025 Timeout: TIMEOUT=4, no ack -> expect:
- stb held exactly 4 cycles.
- nberr low, ndtack stays 1.
- return to IDLE after AS high.
REQ-026 Collision: ack and err in the same cycle -> expect nberr=0 and ndtack=1 (err wins).
REQ-027 Reset mid-BUS (stb=1) -> cyc/stb=0 immediately, asynchronously; after release, no cycle until a fresh AS falling edge.
REQ-028 CPU abort: AS high while in BUS, then ack -> expect IDLE with ndtack never low; next cycle proceeds normally.
